dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage address/data signals and the backing data memory.
- Serves load hits in the same cycle and refills 4-word lines on a read miss.
- Forwards every store to memory.
- Raises `stall` to the hazard logic while a miss or store is outstanding, so the pipeline freezes F/D/E/M until the access completes.

Parameters:
- DATA_WIDTH, 32, CPU and memory data width (fixed 32; other values unsupported)
- LINES, 64, number of cache lines, power of two ≥ 2
- Derived: IDX_W = log2(LINES); offset = addr[3:0]; index = addr[4+IDX_W-1:4]; tag = addr[31:4+IDX_W]

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- addr  in  32  byte address from memory stage (ALUResultM)
- wdata  in  32  store data (WriteDataM)
- we  in  1  store request (MemWriteM)
- re  in  1  load request (ResultSrcM==01)
- AddrMode  in  1  0=word access, 1=byte access
- rdata  out  32  load data; byte mode zero-extended
- stall  out  1  access not complete; pipeline must hold all inputs stable
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word-aligned byte address (bits[1:0]=0)
- mem_wdata  out  32  write data, byte replicated to all lanes in byte mode
- mem_wstrb  out  4  byte enables; 1111 for word, one-hot by addr[1:0] for byte
- mem_rdata  in  32  read data, valid in the mem_ack cycle
- mem_ack  in  1  request accepted/completed this cycle

Behaviour:
- Storage:
  - data array LINES×4×32.
  - tag array LINES×(32-4-IDX_W).
  - valid[LINES] as flops.
- Hit: valid[index] && tag match. Word access ignores addr[1:0]; byte lane selected by addr[1:0].
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - re && hit && !we: rdata driven combinationally, stall=0, zero extra latency.
  - re && miss && !we: stall=1 combinationally; next state REFILL with word counter=0.
  - we (priority over re): stall=1; next state WRITE.
  - Neither: stall=0, rdata=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {addr[31:4], cnt, 2'b00}.
  - Request held stable until mem_ack. On each ack, mem_rdata is written to data[index][cnt] and cnt increments.
  - On the ack with cnt==3: tag written, valid set, next state IDLE.
  - stall=1 throughout. The re-evaluation in IDLE then hits and releases stall.
  - Read-miss latency is 4 acks + 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, address/wdata/wstrb as above, stall=1.
  - On mem_ack: if hit, the addressed word or byte lane in the cache is updated the same edge; miss leaves the cache untouched (no allocate). Next state DONE.
- DONE:
  - stall=0 for exactly one cycle, so the held store retires without being reissued.
  - Next state IDLE.
- Memory handshake:
  - mem_ack while mem_req=0 is ignored.
  - Ack in the first cycle of req is legal; any number of wait cycles is allowed.
- Reset, including mid-refill or mid-write:
  - Next edge: state=IDLE, cnt=0, all valid=0, mem_req=0.
  - Combinational outputs follow IDLE.
  - A partially refilled line is never marked valid.
  - Data/tag arrays need no reset.
- Inputs change only while stall=0. Behaviour under input change while stalled is undefined.
- Accesses are aligned; word access ignores addr[1:0].

Test Plan:
- Cold read: rst, then re=1 addr=0x00000104 word, memory returns 0x11,0x22,0x33,0x44 with ack every cycle.
  - mem_addr 0x100,0x104,0x108,0x10C in order.
  - stall high 5 cycles, then rdata=0x22 with stall=0.
- Hit after refill: re addr=0x10C → rdata=0x44, stall=0 same cycle, mem_req never asserted.
- Byte store hit: we=1 AddrMode=1 addr=0x105 wdata=0xAB.
  - mem_wstrb=0010, mem_wdata=0xABABABAB; stall high until ack, then one DONE cycle with stall=0.
  - A subsequent word load of 0x104 returns 0x0000AB22.
  - A byte load of 0x105 returns 0x000000AB.
- Write miss, no allocate: we addr=0x2000 word 0x55 → one memory write; a later re 0x2000 misses and refills.
- Conflict eviction (LINES=64): load 0x104, then load 0x504 (same index, different tag) → both miss, and the second refill replaces the line.
- Reset mid-refill plus wait states:
  - ack arrives every 3rd cycle; assert rst after 2 acks.
  - Next cycle mem_req=0 and stall=0 with re low.
  - Re-issuing re 0x104 performs a full 4-word refill.

Source files
------------

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through, no-write-allocate data cache
// Load hits return in the same cycle; read misses refill a 4-word line; every store goes to memory.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    input  logic                  AddrMode,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - 4 - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES*4];

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_woff;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_word;
    logic [7:0]            w_byte;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_merge;
    logic                  w_last_ack;

    assign w_idx      = addr[4+IDX_W-1:4];
    assign w_tag      = addr[31:4+IDX_W];
    assign w_woff     = addr[3:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word     = r_data[{w_idx, w_woff}];
    assign w_wdata    = AddrMode ? {4{wdata[7:0]}} : wdata;
    assign w_wstrb    = AddrMode ? (4'b0001 << addr[1:0]) : 4'b1111;
    assign w_last_ack = (r_state == S_REFILL) && mem_ack && (r_cnt == 2'd3);

    always_comb begin
        w_byte = w_word[7:0];
        case (addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    // Store-hit merge: only the enabled lanes take the new data.
    always_comb begin
        w_merge = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_wstrb[i]) w_merge[8*i +: 8] = w_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_REFILL && mem_ack) r_cnt <= r_cnt + 2'd1;
            else if (r_state == S_IDLE)         r_cnt <= 2'd0;
            if (w_last_ack) r_valid[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && mem_ack) r_data[{w_idx, r_cnt}] <= mem_rdata;
        if (w_last_ack) r_tag[w_idx] <= w_tag;
        if (r_state == S_WRITE && mem_ack && w_hit) r_data[{w_idx, w_woff}] <= w_merge;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (we)               w_next = S_WRITE;
                else if (re && !w_hit) w_next = S_REFILL;
            end
            S_REFILL: if (w_last_ack) w_next = S_IDLE;
            S_WRITE:  if (mem_ack)    w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdata     = '0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (we) begin
                    stall = 1'b1;
                end else if (re) begin
                    if (w_hit) rdata = AddrMode ? {24'd0, w_byte} : w_word;
                    else       stall = 1'b1;
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addr[31:4], r_cnt, 2'b00};
            end
            S_WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[31:2], 2'b00};
                mem_wdata = w_wdata;
                mem_wstrb = w_wstrb;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - scoreboard bench for dcache_wt with a flat memory reference model
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        AddrMode = 1'b0;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    dcache_wt #(.DATA_WIDTH(32), .LINES(64)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .AddrMode(AddrMode), .rdata(rdata), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] rq[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          mv [64];
    logic [21:0] mt [64];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_hs = 0;
    int          ack_mode = 2;
    int          wcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder and output monitor share one edge so a handshake is seen exactly once.
    always @(negedge clk) begin
        logic        ack;
        logic [31:0] w;
        mreq_t       e;
        ack = 1'b0;
        if (rst) begin
            wcnt = 0;
        end else begin
            case (ack_mode)
                0: ack = ($urandom_range(0, 1) == 1);
                1: begin
                    if (mem_req) begin
                        if (wcnt == 2) begin ack = 1'b1; wcnt = 0; end
                        else wcnt++;
                    end else wcnt = 0;
                end
                default: ack = 1'b1;
            endcase
        end
        mem_ack   = ack;
        mem_rdata = mem_req ? mem_rd(mem_addr) : $urandom;
        if (mem_req && mem_ack) begin
            n_hs++;
            if (mq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_mem_req: got addr %h we %b expected none", mem_addr, mem_we);
            end else begin
                e = mq.pop_front();
                check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                check("mem_addr", mem_addr, e.a);
                if (e.we) begin
                    check("mem_wdata", mem_wdata, e.d);
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.s});
                end
            end
            if (mem_we) begin
                w = mem_rd(mem_addr);
                for (int i = 0; i < 4; i++)
                    if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                mem[mem_addr] = w;
            end
        end
        if (!rst && re && !we && !stall) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_load_retire: got rdata %h expected none", rdata);
            end else begin
                check("rdata", rdata, rq.pop_front());
            end
        end
    end

    task automatic do_op(input bit is_st, input bit bmode, input logic [31:0] a,
                         input logic [31:0] d, output int cyc);
        logic [31:0] wa, rep, nw, ex;
        logic [3:0]  strb;
        int          idx;
        bit          hit;
        wa  = {a[31:2], 2'b00};
        idx = int'(a[9:4]);
        hit = 1'b0;
        if (is_st) begin
            rep  = bmode ? {4{d[7:0]}} : d;
            strb = bmode ? (4'b0001 << a[1:0]) : 4'b1111;
            mq.push_back('{1'b1, wa, rep, strb});
            nw = ref_rd(wa);
            for (int i = 0; i < 4; i++)
                if (strb[i]) nw[8*i +: 8] = rep[8*i +: 8];
            ref_mem[wa] = nw;
        end else begin
            hit = mv[idx] && (mt[idx] == a[31:10]);
            if (!hit) begin
                for (int k = 0; k < 4; k++)
                    mq.push_back('{1'b0, {a[31:4], 4'(k * 4)}, 32'd0, 4'd0});
                mv[idx] = 1'b1;
                mt[idx] = a[31:10];
            end
            ex = bmode ? ((ref_rd(wa) >> (8 * a[1:0])) & 32'hFF) : ref_rd(wa);
            rq.push_back(ex);
        end
        addr     = a;
        wdata    = is_st ? d : $urandom;
        we       = is_st;
        re       = !is_st;
        AddrMode = bmode;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (cyc == 0 && !is_st && hit) begin
                check("hit_stall", {31'd0, stall}, 32'd0);
                check("hit_mem_req", {31'd0, mem_req}, 32'd0);
            end
            if (!stall) break;
            cyc++;
            if (cyc > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL op_timeout: got stall after %0d cycles expected release", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic do_idle();
        addr = $urandom;
        we   = 1'b0;
        re   = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_rdata", rdata, 32'd0);
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, hs0, tg, ix, wo, bb;
        bit st, bm;
        logic [31:0] a;
        clear_model();
        for (int k = 0; k < 4; k++) begin
            mem[32'h100 + 32'(4 * k)]     = 32'h11 * 32'(k + 1);
            ref_mem[32'h100 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;

        ack_mode = 2;
        do_op(0, 0, 32'h104, 0, cyc);
        check("cold_stall_cycles", cyc, 5);
        hs0 = n_hs;
        do_op(0, 0, 32'h10C, 0, cyc);
        check("hit_cycles", cyc, 0);
        check("hit_no_mem", n_hs, hs0);
        do_op(1, 1, 32'h105, 32'h000000AB, cyc);
        check("store_stall_cycles", cyc, 2);
        do_op(0, 0, 32'h104, 0, cyc);
        check("merged_hit_cycles", cyc, 0);
        do_op(0, 1, 32'h105, 0, cyc);
        do_op(1, 0, 32'h2000, 32'h55, cyc);
        do_op(0, 0, 32'h2000, 0, cyc);
        check("write_no_alloc_miss", cyc, 5);
        do_op(0, 0, 32'h504, 0, cyc);
        check("conflict_miss_504", cyc, 5);
        do_op(0, 0, 32'h104, 0, cyc);
        check("conflict_miss_104", cyc, 5);
        do_op(0, 0, 32'h504, 0, cyc);
        check("conflict_miss_504b", cyc, 5);
        do_idle();

        for (int n = 0; n < 400; n++) begin
            ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            tg = $urandom_range(0, 3);
            ix = $urandom_range(0, 7);
            wo = $urandom_range(0, 3);
            bm = $urandom_range(0, 1);
            bb = bm ? $urandom_range(0, 3) : 0;
            a  = 32'((tg << 10) | (ix << 4) | (wo << 2) | bb);
            case ($urandom_range(0, 9))
                0, 1:    do_idle();
                2, 3, 4: begin st = 1'b1; do_op(st, bm, a, $urandom, cyc); end
                default: begin st = 1'b0; do_op(st, bm, a, 0, cyc); end
            endcase
        end

        // Reset in the middle of a refill with wait states.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        ack_mode = 1;
        for (int k = 0; k < 4; k++)
            mq.push_back('{1'b0, 32'h100 + 32'(4 * k), 32'd0, 4'd0});
        hs0      = n_hs;
        addr     = 32'h104;
        AddrMode = 1'b0;
        we       = 1'b0;
        re       = 1'b1;
        cyc      = 0;
        while (n_hs < hs0 + 2 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("abort_acks_seen", n_hs - hs0, 2);
        #1;
        rst = 1'b1;
        re  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_pending", mq.size(), 2);
        mq.delete();
        clear_model();
        @(posedge clk);
        #1;
        do_op(0, 0, 32'h104, 0, cyc);
        check("refill_after_reset_cycles", cyc, 13);

        do_idle();
        check("mem_queue_empty", mq.size(), 0);
        check("load_queue_empty", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
